// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the icache, and fills the IF|ID latch.
// Redirects that arrive during a miss squash the in-flight wrong-path word.
module fetch_stage #(
   parameter int                WORD_W  = 32,
   parameter logic [WORD_W-1:0] PC_INIT = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ihit,
   input  logic [WORD_W-1:0]     imemload,
   output logic                  imemREN,
   output logic [WORD_W-1:0]     imemaddr,
   input  logic                  stall,
   input  logic                  redirect_en,
   input  logic [WORD_W-1:0]     redirect_pc,
   input  logic                  halt,
   output logic [2*WORD_W-1:0]   ifid,
   output logic                  ifid_valid
);

   typedef enum logic [1:0] {FETCH, SQUASH, HALTED} state_t;

   state_t              state_q;
   logic [WORD_W-1:0]   pc_q, pend_pc_q;
   logic [2*WORD_W-1:0] ifid_q;
   logic                ifid_valid_q;

   logic [WORD_W-1:0]   pc_plus;
   logic [WORD_W-1:0]   target;

   assign pc_plus    = pc_q + WORD_W'(4);
   assign target     = redirect_pc & ~WORD_W'(3);
   assign imemREN    = (state_q != HALTED);
   assign imemaddr   = pc_q;
   assign ifid       = ifid_q;
   assign ifid_valid = ifid_valid_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= FETCH;
         pc_q         <= PC_INIT;
         pend_pc_q    <= '0;
         ifid_q       <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (halt) begin
                  state_q      <= HALTED;
                  ifid_q       <= '0;
                  ifid_valid_q <= 1'b0;
               end else if (redirect_en) begin
                  ifid_q       <= '0;
                  ifid_valid_q <= 1'b0;
                  // On a miss the icache address must stay put until the word drains.
                  if (ihit) begin
                     pc_q <= target;
                  end else begin
                     pend_pc_q <= target;
                     state_q   <= SQUASH;
                  end
               end else if (ihit) begin
                  if (!stall) begin
                     ifid_q       <= {imemload, pc_plus};
                     ifid_valid_q <= 1'b1;
                     pc_q         <= pc_plus;
                  end
               end else if (!stall) begin
                  ifid_q       <= '0;
                  ifid_valid_q <= 1'b0;
               end
            end
            SQUASH: begin
               ifid_q       <= '0;
               ifid_valid_q <= 1'b0;
               if (halt) begin
                  state_q <= HALTED;
               end else if (redirect_en) begin
                  pend_pc_q <= target;
                  if (ihit) begin
                     pc_q    <= target;
                     state_q <= FETCH;
                  end
               end else if (ihit) begin
                  pc_q    <= pend_pc_q;
                  state_q <= FETCH;
               end
            end
            HALTED: begin
               ifid_q       <= '0;
               ifid_valid_q <= 1'b0;
            end
            default: state_q <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plan scenarios followed by random traffic, checked cycle-by-cycle against a reference model.
module tb_fetch_stage;

   localparam logic [31:0] PC_INIT = 32'h0;

   logic        CLK = 1'b0;
   logic        RST, ihit, stall, redirect_en, halt;
   logic [31:0] imemload, redirect_pc, imemaddr;
   logic        imemREN, ifid_valid;
   logic [63:0] ifid;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: "halted" and "squashing" flags plus architectural values
   bit          m_halted, m_sq;
   logic [31:0] m_pc, m_pend;
   logic [63:0] m_ifid;
   bit          m_v;

   fetch_stage #(.WORD_W(32), .PC_INIT(PC_INIT)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
      .imemaddr(imemaddr), .stall(stall), .redirect_en(redirect_en),
      .redirect_pc(redirect_pc), .halt(halt), .ifid(ifid), .ifid_valid(ifid_valid)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      logic [31:0] tgt;
      tgt = {redirect_pc[31:2], 2'b00};
      if (RST) begin
         m_pc = PC_INIT; m_pend = 0; m_halted = 0; m_sq = 0; m_ifid = 0; m_v = 0;
      end else if (m_halted) begin
         m_ifid = 0; m_v = 0;
      end else if (m_sq) begin
         m_ifid = 0; m_v = 0;
         if (halt) begin m_halted = 1; m_sq = 0; end
         else if (redirect_en) begin
            m_pend = tgt;
            if (ihit) begin m_pc = tgt; m_sq = 0; end
         end else if (ihit) begin m_pc = m_pend; m_sq = 0; end
      end else begin
         if (halt) begin m_halted = 1; m_ifid = 0; m_v = 0; end
         else if (redirect_en) begin
            m_ifid = 0; m_v = 0;
            if (ihit) m_pc = tgt;
            else begin m_pend = tgt; m_sq = 1; end
         end else if (ihit) begin
            if (!stall) begin m_ifid = {imemload, m_pc + 32'd4}; m_v = 1; m_pc = m_pc + 32'd4; end
         end else if (!stall) begin m_ifid = 0; m_v = 0; end
      end
   endtask

   task automatic step(input bit rst, input bit hit, input logic [31:0] load, input bit stl,
                       input bit red, input logic [31:0] rpc, input bit hlt);
      RST = rst; ihit = hit; imemload = load; stall = stl;
      redirect_en = red; redirect_pc = rpc; halt = hlt;
      @(posedge CLK);
      model_update();
      #1;
      chk("imemaddr",   imemaddr,   m_pc);
      chk("imemREN",    imemREN,    !m_halted);
      chk("ifid",       ifid,       m_ifid);
      chk("ifid_valid", ifid_valid, m_v);
   endtask

   initial begin
      // reset
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("rst_addr", imemaddr, 32'h0);
      chk("rst_ren", imemREN, 1'b1);
      chk("rst_valid", ifid_valid, 1'b0);

      // 1: sequential hits
      step(0, 1, 32'h20010005, 0, 0, 0, 0);
      chk("t1_ifid0", ifid, {32'h20010005, 32'h4});
      step(0, 1, 32'h20020007, 0, 0, 0, 0);
      chk("t1_ifid1", ifid, {32'h20020007, 32'h8});
      chk("t1_addr", imemaddr, 32'h8);

      // 2: stall with hit at pc 0x10
      step(0, 1, 32'h11111111, 0, 1, 32'h10, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 32'hAAAA0000, 1, 0, 0, 0);
      chk("t2_held_pc", imemaddr, 32'h10);
      step(0, 1, 32'hAAAA0000, 0, 0, 0, 0);
      chk("t2_pc", imemaddr, 32'h14);
      chk("t2_ifid", ifid, {32'hAAAA0000, 32'h14});

      // 3: redirect on hit
      step(0, 1, 0, 0, 1, 32'h20, 0);
      step(0, 1, 32'hDEAD0001, 0, 1, 32'h103, 0);
      chk("t3_pc", imemaddr, 32'h100);
      chk("t3_valid", ifid_valid, 1'b0);

      // 4: redirects during a miss
      step(0, 1, 0, 0, 1, 32'h40, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h200, 0);
      step(0, 0, 0, 0, 1, 32'h300, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("t4_addr_hold", imemaddr, 32'h40);
      step(0, 1, 32'hBAD00040, 0, 0, 0, 0);
      chk("t4_pc", imemaddr, 32'h300);
      chk("t4_valid", ifid_valid, 1'b0);

      // 5: halt beats redirect, then RST recovers
      step(0, 1, 32'h1, 0, 1, 32'h500, 1);
      chk("t5_ren", imemREN, 1'b0);
      step(0, 1, 32'h2, 0, 1, 32'h600, 0);
      step(0, 1, 32'h3, 0, 0, 0, 0);
      chk("t5_frozen", imemaddr, 32'h300);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("t5_rst_ren", imemREN, 1'b1);

      // 6: wrap and reset during SQUASH
      step(0, 1, 0, 0, 1, 32'hFFFFFFFF, 0);
      step(0, 1, 32'hCAFEF00D, 0, 0, 0, 0);
      chk("t6_wrap", ifid, {32'hCAFEF00D, 32'h0});
      step(0, 0, 0, 0, 1, 32'h700, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 32'h5, 0, 0, 0, 0);
      chk("t6_rst_sq", imemaddr, PC_INIT + 32'h4);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 2) != 0),
              $urandom,
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 6) == 0),
              $urandom,
              ($urandom_range(0, 79) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
